// File: rtl/alu_issue.sv
// alu_issue: decodes one instruction into ALU operands and op select, then holds them in an output register for the ALU stage.
// Latency: an accepted instruction appears on the outputs exactly 1 cycle later. A new instruction can be accepted every cycle.
// Backpressure: while out_valid && !out_ready the outputs are frozen and in_ready is 0. flush kills the held and the incoming instruction.
//
// Ports:
//   clk, rst_n                         clock and asynchronous active-low reset
//   in_valid/in_ready, flush           decoded-instruction handshake from ID, and kill
//   opcode, funct3, funct7_5           instruction fields that select the ALU op
//   pc, imm, rs1_*, rs2_*, rd_addr     operand sources and destination
//   fwd_mem_*, fwd_wb_*                EX/MEM and MEM/WB bypass sources
//   out_valid/out_ready                handshake toward the ALU stage
//   alu_d0, alu_d1, alu_s              registered operands and op select
//   out_rd, out_we, out_illegal        registered destination, write enable and illegal flag
//
// Build option: define ALU_ISSUE_FORWARDING_EN to enable operand bypass from fwd_mem_*/fwd_wb_*.
// When it is not defined, those ports are ignored and hazards must be resolved upstream by stalling.
module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_addr,
    input  logic            fwd_mem_we,
    input  logic [4:0]      fwd_mem_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic            fwd_wb_we,
    input  logic [4:0]      fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_d0,
    output logic [XLEN-1:0] alu_d1,
    output logic [3:0]      alu_s,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_illegal
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

`ifdef ALU_ISSUE_FORWARDING_EN
    // x0 is hard-wired to zero; the youngest producer (EX/MEM) wins over MEM/WB.
    assign rs1_val = (rs1_addr == 5'd0)                         ? '0           :
                     (fwd_mem_we && (fwd_mem_rd == rs1_addr))   ? fwd_mem_data :
                     (fwd_wb_we  && (fwd_wb_rd  == rs1_addr))   ? fwd_wb_data  :
                                                                  rs1_data;
    assign rs2_val = (rs2_addr == 5'd0)                         ? '0           :
                     (fwd_mem_we && (fwd_mem_rd == rs2_addr))   ? fwd_mem_data :
                     (fwd_wb_we  && (fwd_wb_rd  == rs2_addr))   ? fwd_wb_data  :
                                                                  rs2_data;
`else
    // Bypass ports stay on the interface so both builds are pin-compatible.
    logic unused_fwd;
    assign unused_fwd = ^{fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_we, fwd_wb_rd, fwd_wb_data};
    assign rs1_val = (rs1_addr == 5'd0) ? '0 : rs1_data;
    assign rs2_val = (rs2_addr == 5'd0) ? '0 : rs2_data;
`endif

    // Decode
    logic [3:0]      dec_s;
    logic [XLEN-1:0] dec_d0;
    logic [XLEN-1:0] dec_d1;
    logic            dec_legal;
    logic [3:0]      f3_op;

    // funct3 map shared by OP and OP-IMM; the SUB override only applies to OP.
    always_comb begin
        f3_op = OP_ADD;
        case (funct3)
            3'b000:  f3_op = OP_ADD;
            3'b001:  f3_op = OP_SLL;
            3'b010:  f3_op = OP_SLT;
            3'b011:  f3_op = OP_SLTU;
            3'b100:  f3_op = OP_XOR;
            3'b101:  f3_op = funct7_5 ? OP_SRA : OP_SRL;
            3'b110:  f3_op = OP_OR;
            default: f3_op = OP_AND;
        endcase
    end

    always_comb begin
        dec_s     = OP_ADD;
        dec_d0    = '0;
        dec_d1    = '0;
        dec_legal = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec_s  = (funct3 == 3'b000 && funct7_5) ? OP_SUB : f3_op;
                dec_d0 = rs1_val;
                dec_d1 = rs2_val;
            end
            OPC_OP_IMM: begin
                dec_s  = f3_op;
                dec_d0 = rs1_val;
                dec_d1 = imm;
            end
            OPC_LUI: begin
                dec_d1 = imm;
            end
            OPC_AUIPC: begin
                dec_d0 = pc;
                dec_d1 = imm;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Handshake
    logic load;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign load     = in_valid && in_ready;

    // Data fields only move on a load, so they stay frozen through stalls, idle and flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            alu_d0      <= '0;
            alu_d1      <= '0;
            alu_s       <= OP_ADD;
            out_rd      <= 5'd0;
            out_we      <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            alu_d0      <= dec_d0;
            alu_d1      <= dec_d1;
            alu_s       <= dec_s;
            out_rd      <= rd_addr;
            out_we      <= dec_legal && (rd_addr != 5'd0);
            out_illegal <= !dec_legal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
